nco_sweep_ctrl: RTL and testbench

NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

---
 rtl/nco_sweep_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
// Tuning-word sweep controller for an NCO: ramps f_out from f_start to f_stop.
// Define NCO_SWEEP_BIDIR_EN for a triangle (up then down) sweep.
module nco_sweep_ctrl #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               continuous,
    input  logic [31:0]        f_start,
    input  logic [31:0]        f_stop,
    input  logic [31:0]        f_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [31:0]        f_out,
    output logic               f_valid,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE,
        DWELL,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [31:0]          start_q, start_d;
    logic [31:0]          stop_q, stop_d;
    logic [31:0]          step_q, step_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic                 cont_q, cont_d;
    logic [31:0]          f_out_d;
    logic                 valid_d;
    logic                 busy_d;
    logic                 done_d;
    logic                 err_d;

    logic [32:0]          sum;
    logic [31:0]          up_word;
    logic [31:0]          nxt_word;
    logic                 at_end;
    logic                 bad_cfg;

    // 33-bit sum so a carry-out also clamps to f_stop
    assign sum     = {1'b0, f_out} + {1'b0, step_q};
    assign up_word = (sum > {1'b0, stop_q}) ? stop_q : sum[31:0];
    assign bad_cfg = (f_step == 32'd0) || (f_start > f_stop);

`ifdef NCO_SWEEP_BIDIR_EN
    logic        dir_q, dir_d;
    logic        dir_nxt;
    logic [32:0] diff;
    logic [31:0] down_word;

    assign diff      = {1'b0, f_out} - {1'b0, step_q};
    assign down_word = (diff[32] || (diff[31:0] < start_q)) ?
                       start_q : diff[31:0];

    // a pass ends back at f_start, or at once when start equals stop
    assign at_end = dir_q ? (f_out == start_q) :
                    ((f_out == stop_q) && (stop_q == start_q));

    always_comb begin
        nxt_word = up_word;
        dir_nxt  = dir_q;
        if (at_end) begin
            nxt_word = up_word;
            dir_nxt  = 1'b0;
        end else if (dir_q) begin
            nxt_word = down_word;
            dir_nxt  = 1'b1;
        end else if (f_out == stop_q) begin
            nxt_word = down_word;
            dir_nxt  = 1'b1;
        end
    end
`else
    assign at_end   = (f_out == stop_q);
    assign nxt_word = at_end ? start_q : up_word;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        stop_d  = stop_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;
        f_out_d = f_out;
        valid_d = 1'b0;
        busy_d  = busy;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef NCO_SWEEP_BIDIR_EN
        dir_d   = dir_q;
`endif
        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (abort) begin
                    state_d = IDLE;
                end else if (start && bad_cfg) begin
                    err_d = 1'b1;
                end else if (start) begin
                    start_d = f_start;
                    stop_d  = f_stop;
                    step_d  = f_step;
                    dwell_d = dwell;
                    cont_d  = continuous;
                    f_out_d = f_start;
                    cnt_d   = dwell;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = DWELL;
`ifdef NCO_SWEEP_BIDIR_EN
                    dir_d   = 1'b0;
`endif
                end
            end
            DWELL: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (at_end && !cont_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    f_out_d = nxt_word;
                    cnt_d   = dwell_q;
                    valid_d = 1'b1;
`ifdef NCO_SWEEP_BIDIR_EN
                    dir_d   = dir_nxt;
`endif
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= '0;
            stop_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
            f_out   <= '0;
            f_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
`ifdef NCO_SWEEP_BIDIR_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            stop_q  <= stop_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
            f_out   <= f_out_d;
            f_valid <= valid_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
`ifdef NCO_SWEEP_BIDIR_EN
            dir_q   <= dir_d;
`endif
        end
    end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl: expected words queued at start,
// popped on each f_valid pulse.
module tb_nco_sweep_ctrl;

    typedef struct {
        logic [31:0] f;
        int          gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        continuous;
    logic [31:0] f_start;
    logic [31:0] f_stop;
    logic [31:0] f_step;
    logic [15:0] dwell;
    logic [31:0] f_out;
    logic        f_valid;
    logic        busy;
    logic        done;
    logic        err;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_vcyc = 0;
    int   done_cyc = 0;
    int   n_done = 0;
    int   n_err = 0;

    nco_sweep_ctrl #(.DWELL_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .continuous (continuous),
        .f_start    (f_start),
        .f_stop     (f_stop),
        .f_step     (f_step),
        .dwell      (dwell),
        .f_out      (f_out),
        .f_valid    (f_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (f_valid) begin
                chk("busy_on_valid", 32'(busy), 32'd1);
                chk("valid_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("f_out", f_out, e.f);
                    if (e.gap != 0)
                        chk("hold", 32'(cyc - last_vcyc), 32'(e.gap));
                end
                last_vcyc = cyc;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                chk("busy_on_done", 32'(busy), 32'd0);
            end
            if (err) n_err++;
        end
    end

    task automatic push(input logic [31:0] f, input int gap);
        exp_t e;
        e.f = f;
        e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic go(input logic [31:0] fs, input logic [31:0] fe,
                      input logic [31:0] st, input logic [15:0] dw,
                      input logic cont, input logic ab);
        @(posedge clk); #1;
        f_start = fs;
        f_stop = fe;
        f_step = st;
        dwell = dw;
        continuous = cont;
        start = 1'b1;
        abort = ab;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        f_start = $urandom;
        f_stop = $urandom;
        f_step = $urandom;
        dwell = 16'($urandom_range(0, 7));
        continuous = ~cont;
    endtask

    task automatic wait_done(input int max);
        int n0 = n_done;
        for (int i = 0; i < max && n_done == n0; i++) @(negedge clk);
        #1;
        chk("done_seen", 32'(n_done - n0), 32'd1);
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int e0;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        continuous = 1'b0;
        f_start = 32'd0;
        f_stop = 32'd0;
        f_step = 32'd0;
        dwell = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_f_out", f_out, 32'd0);
        chk("rst_flags", {28'd0, f_valid, busy, done, err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

`ifdef NCO_SWEEP_BIDIR_EN
        push(100, 0); push(110, 1); push(120, 1); push(130, 1);
        push(120, 1); push(110, 1); push(100, 1);
        go(100, 130, 10, 0, 1'b0, 1'b0);
        wait_done(100);
        chk("bidir_done_lat", 32'(done_cyc - last_vcyc), 32'd1);
        chk("bidir_last", f_out, 32'd100);
`else
        // basic ramp with dwell 2
        push(100, 0); push(110, 3); push(120, 3); push(130, 3);
        go(100, 130, 10, 2, 1'b0, 1'b0);
        wait_done(100);
        chk("done_lat", 32'(done_cyc - last_vcyc), 32'd3);
        idle(1);
        chk("busy_after", 32'(busy), 32'd0);
        chk("hold_stop", f_out, 32'd130);

        push(0, 0); push(10, 1); push(20, 1); push(25, 1);
        go(0, 25, 10, 0, 1'b0, 1'b0);
        wait_done(50);
        chk("clamp_done_lat", 32'(done_cyc - last_vcyc), 32'd1);

        push(32'hFFFF_FFF0, 0); push(32'hFFFF_FFFF, 1);
        go(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0, 1'b0, 1'b0);
        wait_done(50);

        e0 = n_err;
        go(10, 20, 0, 0, 1'b0, 1'b0);
        idle(3);
        chk("rej_step_err", 32'(n_err - e0), 32'd1);
        chk("rej_step_busy", 32'(busy), 32'd0);
        chk("rej_step_fout", f_out, 32'hFFFF_FFFF);
        go(50, 40, 5, 0, 1'b0, 1'b0);
        idle(3);
        chk("rej_order_err", 32'(n_err - e0), 32'd2);

        // continuous, aborted on the second 120
        push(100, 0); push(110, 1); push(120, 1); push(130, 1);
        push(100, 1); push(110, 1); push(120, 1);
        e0 = n_done;
        go(100, 130, 10, 0, 1'b1, 1'b0);
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        chk("cont_reached", 32'(sb.size()), 32'd0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_fout", f_out, 32'd120);
        chk("abort_busy", 32'(busy), 32'd0);
        idle(10);
        chk("abort_hold", f_out, 32'd120);
        chk("abort_no_done", 32'(n_done - e0), 32'd0);

        e0 = n_err;
        go(1, 9, 1, 0, 1'b0, 1'b1);
        idle(5);
        chk("sa_busy", 32'(busy), 32'd0);
        chk("sa_fout", f_out, 32'd120);
        chk("sa_err", 32'(n_err - e0), 32'd0);

        push(77, 0);
        go(77, 77, 5, 3, 1'b0, 1'b0);
        wait_done(50);
        chk("single_done_lat", 32'(done_cyc - last_vcyc), 32'd4);

        // reset mid-sweep while start is held
        push(200, 0);
        go(200, 300, 10, 5, 1'b0, 1'b0);
        idle(2);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("mid_rst_fout", f_out, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        idle(8);
        chk("mid_rst_idle", 32'(busy), 32'd0);
        chk("mid_rst_sb", 32'(sb.size()), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
